// File: rtl/wb_commit_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit_queue
// Description : In-order writeback commit FIFO with youngest-match forwarding.
// Revision    : 1.0
// ============================================================================
module wb_commit_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     wbA_i,
    input  logic [ADDR_W-1:0]        wbAddrA_i,
    input  logic [DATA_W-1:0]        wbValA_i,
    output logic                     full_o,
    output logic                     regWe_o,
    output logic [ADDR_W-1:0]        regAddr_o,
    output logic [DATA_W-1:0]        regVal_o,
    input  logic                     regReady_i,
    input  logic [ADDR_W-1:0]        fwdAddr_i,
    output logic                     fwdHit_o,
    output logic [DATA_W-1:0]        fwdVal_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] val_q  [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic w_empty;
    logic w_wr_valid;
    logic w_pop;
    logic w_push;

    assign w_empty    = (count_q == '0);
    assign w_wr_valid = wbA_i && (wbAddrA_i != '0);
    assign w_pop      = !w_empty && regReady_i;
    assign w_push     = w_wr_valid && ((count_q < C_DEPTH) || w_pop);

    assign regWe_o    = !w_empty;
    assign regAddr_o  = w_empty ? '0 : addr_q[rd_ptr_q];
    assign regVal_o   = w_empty ? '0 : val_q[rd_ptr_q];
    assign full_o     = (count_q == C_DEPTH);
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (w_wr_valid && !w_push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry payload needs no reset: occupancy gates every read of it.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            addr_q[wr_ptr_q] <= wbAddrA_i;
            val_q[wr_ptr_q]  <= wbValA_i;
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    logic [PTR_W-1:0] w_idx;
    always_comb begin
        fwdHit_o = 1'b0;
        fwdVal_o = '0;
        w_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (fwdAddr_i != '0) &&
                (addr_q[w_idx] == fwdAddr_i)) begin
                fwdHit_o = 1'b1;
                fwdVal_o = val_q[w_idx];
            end
        end
    end

endmodule
`default_nettype wire
